// File: rtl/lcd_pkg.sv
// lcd_pkg: definitions shared by the LCD host model and its buffers.
//   - controller command codes (CMD_IDLE is what the command port shows
//     whenever no strobe is present)
//   - host state encoding
//   - image geometry (PIX_N pixels, PIX_AW address bits)
//   - cmd_is_reserved(): flags script codes the controller does not define
package lcd_pkg;

    localparam int PIX_N  = 64;
    localparam int PIX_AW = 6;

    typedef enum logic [3:0] {
        CMD_WRITE          = 4'd0,
        CMD_SHIFT_UP       = 4'd1,
        CMD_SHIFT_DOWN     = 4'd2,
        CMD_SHIFT_LEFT     = 4'd3,
        CMD_SHIFT_RIGHT    = 4'd4,
        CMD_MAX            = 4'd5,
        CMD_MIN            = 4'd6,
        CMD_AVE            = 4'd7,
        CMD_LEFT_ROTATION  = 4'd8,
        CMD_RIGHT_ROTATION = 4'd9,
        CMD_MIRROR_X       = 4'd10,
        CMD_MIRROR_Y       = 4'd11,
        CMD_IDLE           = 4'hF
    } lcd_cmd_e;

    typedef enum logic [2:0] {
        HS_IDLE     = 3'd0,
        HS_WAIT_RDY = 3'd1,
        HS_HOLD     = 3'd2,
        HS_COLLECT  = 3'd3,
        HS_FIN      = 3'd4
    } host_state_e;

    // Codes 12..15 have no meaning to the controller; they are still issued
    // but mark the run as failed.
    function automatic logic cmd_is_reserved(input logic [3:0] c);
        return (c >= 4'd12);
    endfunction

endpackage

// File: rtl/lcd_pixel_buf.sv
// lcd_pixel_buf: PIX_N x 8 pixel store.
//   clk        : clock, write on rising edge
//   i_we       : write enable
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_addr  : read address
//   o_rd_data  : read data, combinational from i_rd_addr
// Contents are deliberately not reset so a preloaded image survives a reset.
module lcd_pixel_buf
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [PIX_AW-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic [PIX_AW-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);

    logic [7:0] r_mem [PIX_N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lcd_host.sv
// lcd_host: host-side model for the LCD image controller.
// Serves image-ROM reads from a preloaded image, replays a preloaded command
// script over the cmd/cmd_valid/busy handshake, and captures image-RAM
// writes into a result buffer. Reports run_done and a sticky error flag.
//   clk, reset                     : clock, async active-low reset
//   start                          : run request (IDLE/FIN only)
//   img_we/img_addr/img_data       : image preload (IDLE/FIN only)
//   scr_we/scr_addr/scr_data       : script preload (IDLE/FIN only)
//   scr_len                        : script length, sampled on start
//   cmd, cmd_valid                 : command to the controller (Mealy on busy)
//   busy, done                     : controller status
//   IROM_rd, IROM_A, IROM_Q        : image read port (combinational)
//   IRAM_valid, IRAM_A, IRAM_D     : result write from the controller
//   res_rd_addr, res_rd_data       : result buffer read (combinational)
//   wr_count, run_done, error      : run status
module lcd_host
    import lcd_pkg::*;
#(
    parameter  int CMD_DEPTH = 16,
    parameter  int TIMEOUT   = 1024,
    localparam int CW        = $clog2(CMD_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              img_we,
    input  logic [PIX_AW-1:0] img_addr,
    input  logic [7:0]        img_data,
    input  logic              scr_we,
    input  logic [CW-1:0]     scr_addr,
    input  logic [3:0]        scr_data,
    input  logic [CW:0]       scr_len,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    input  logic              IROM_rd,
    input  logic [PIX_AW-1:0] IROM_A,
    output logic [7:0]        IROM_Q,
    input  logic              IRAM_valid,
    input  logic [PIX_AW-1:0] IRAM_A,
    input  logic [7:0]        IRAM_D,
    input  logic [PIX_AW-1:0] res_rd_addr,
    output logic [7:0]        res_rd_data,
    output logic [6:0]        wr_count,
    output logic              run_done,
    output logic              error
);

    localparam logic [2:0] S_IDLE     = HS_IDLE;
    localparam logic [2:0] S_WAIT_RDY = HS_WAIT_RDY;
    localparam logic [2:0] S_HOLD     = HS_HOLD;
    localparam logic [2:0] S_COLLECT  = HS_COLLECT;
    localparam logic [2:0] S_FIN      = HS_FIN;

    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [2:0]     r_state, w_state_next;
    logic [CW:0]    r_ptr, w_ptr_next;
    logic [CW:0]    r_len, w_len_next;
    logic [6:0]     r_wr_count, w_wr_count_next;
    logic           r_run_done, w_run_done_next;
    logic           r_error, w_error_next;
    logic [WDW-1:0] r_wdog;
    logic [3:0]     r_script [CMD_DEPTH];

    logic           w_preload_ok;
    logic           w_counted;
    logic           w_timeout;
    logic           w_ptr_at_end;
    logic           w_issue;
    logic [3:0]     w_cmd_cur;
    logic           w_collect_we;
    logic           w_stray;
    logic [6:0]     w_count_inc;
    logic [6:0]     w_count_final;
    logic [7:0]     w_img_q;

    assign w_preload_ok  = (r_state == S_IDLE) || (r_state == S_FIN);
    assign w_counted     = (r_state == S_WAIT_RDY) || (r_state == S_HOLD) ||
                           (r_state == S_COLLECT);
    assign w_timeout     = w_counted && (r_wdog == WDW'(TIMEOUT - 1));
    assign w_ptr_at_end  = (r_ptr == r_len);
    assign w_cmd_cur     = r_script[r_ptr[CW-1:0]];
    // The watchdog wins over an issue in the same cycle so a run that has
    // already timed out never emits one more strobe.
    assign w_issue       = (r_state == S_WAIT_RDY) && !busy && !w_ptr_at_end &&
                           !w_timeout;
    assign w_collect_we  = IRAM_valid && (r_state == S_COLLECT);
    assign w_stray       = IRAM_valid && (r_state != S_COLLECT);
    assign w_count_inc   = (r_wr_count == 7'd127) ? 7'd127 : r_wr_count + 7'd1;
    // Count as it will stand after this edge, so a write coincident with
    // done is included in the completeness check.
    assign w_count_final = w_collect_we ? w_count_inc : r_wr_count;

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_len_next      = r_len;
        w_wr_count_next = r_wr_count;
        w_run_done_next = r_run_done;
        w_error_next    = r_error;
        case (r_state)
            S_IDLE, S_FIN: begin
                if (start) begin
                    w_ptr_next      = '0;
                    w_wr_count_next = '0;
                    w_len_next      = scr_len;
                    if (scr_len == '0) begin
                        w_state_next    = S_FIN;
                        w_error_next    = 1'b1;
                        w_run_done_next = 1'b1;
                    end else begin
                        w_state_next    = S_WAIT_RDY;
                        w_error_next    = 1'b0;
                        w_run_done_next = 1'b0;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (w_timeout || w_ptr_at_end) begin
                    // Script exhausted without a WRITE, or controller stuck.
                    w_state_next    = S_FIN;
                    w_error_next    = 1'b1;
                    w_run_done_next = 1'b1;
                end else if (!busy) begin
                    w_ptr_next = r_ptr + 1'b1;
                    if (cmd_is_reserved(w_cmd_cur)) begin
                        w_error_next = 1'b1;
                    end
                    w_state_next = (w_cmd_cur == CMD_WRITE) ? S_COLLECT : S_HOLD;
                end
            end
            S_HOLD: begin
                // One idle cycle between strobes; busy is not looked at here.
                if (w_timeout) begin
                    w_state_next    = S_FIN;
                    w_error_next    = 1'b1;
                    w_run_done_next = 1'b1;
                end else begin
                    w_state_next = S_WAIT_RDY;
                end
            end
            S_COLLECT: begin
                if (w_collect_we) begin
                    w_wr_count_next = w_count_inc;
                end
                if (done) begin
                    w_state_next    = S_FIN;
                    w_run_done_next = 1'b1;
                    if (w_count_final != 7'(PIX_N)) begin
                        w_error_next = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next    = S_FIN;
                    w_error_next    = 1'b1;
                    w_run_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // A result write outside COLLECT is dropped but always flagged,
        // even when it coincides with a start that clears the flag.
        if (w_stray) begin
            w_error_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_len      <= '0;
            r_wr_count <= '0;
            r_run_done <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_len      <= w_len_next;
            r_wr_count <= w_wr_count_next;
            r_run_done <= w_run_done_next;
            r_error    <= w_error_next;
        end
    end

    // Watchdog: restarts on any state change or controller write, so it
    // measures the time spent making no progress in a single state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if ((w_state_next != r_state) || IRAM_valid) begin
            r_wdog <= '0;
        end else if (w_counted) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    // Script store: plain register array, not reset.
    always_ff @(posedge clk) begin
        if (scr_we && w_preload_ok) begin
            r_script[scr_addr] <= scr_data;
        end
    end

    lcd_pixel_buf u_image (
        .clk       (clk),
        .i_we      (img_we && w_preload_ok),
        .i_wr_addr (img_addr),
        .i_wr_data (img_data),
        .i_rd_addr (IROM_A),
        .o_rd_data (w_img_q)
    );

    lcd_pixel_buf u_result (
        .clk       (clk),
        .i_we      (w_collect_we),
        .i_wr_addr (IRAM_A),
        .i_wr_data (IRAM_D),
        .i_rd_addr (res_rd_addr),
        .o_rd_data (res_rd_data)
    );

    assign cmd       = w_issue ? w_cmd_cur : CMD_IDLE;
    assign cmd_valid = w_issue;
    assign IROM_Q    = IROM_rd ? w_img_q : 8'd0;
    assign wr_count  = r_wr_count;
    assign run_done  = r_run_done;
    assign error     = r_error;

endmodule

// File: tb/tb_lcd_host.sv
module tb_lcd_host;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       img_we;
    logic [5:0] img_addr;
    logic [7:0] img_data;
    logic       scr_we;
    logic [3:0] scr_addr;
    logic [3:0] scr_data;
    logic [4:0] scr_len;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic [5:0] res_rd_addr;
    logic [7:0] res_rd_data;
    logic [6:0] wr_count;
    logic       run_done;
    logic       error;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         strobe_cnt = 0;
    logic [3:0] strobe_log [8];
    logic       prev_cv = 1'b0;

    always #5 clk = ~clk;

    lcd_host #(.CMD_DEPTH(16), .TIMEOUT(1024)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .img_we      (img_we),
        .img_addr    (img_addr),
        .img_data    (img_data),
        .scr_we      (scr_we),
        .scr_addr    (scr_addr),
        .scr_data    (scr_data),
        .scr_len     (scr_len),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .busy        (busy),
        .done        (done),
        .IROM_rd     (IROM_rd),
        .IROM_A      (IROM_A),
        .IROM_Q      (IROM_Q),
        .IRAM_valid  (IRAM_valid),
        .IRAM_A      (IRAM_A),
        .IRAM_D      (IRAM_D),
        .res_rd_addr (res_rd_addr),
        .res_rd_data (res_rd_data),
        .wr_count    (wr_count),
        .run_done    (run_done),
        .error       (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample the command port, then advance to 1 time unit after the next edge.
    task automatic cyc();
        #1;
        if (cmd_valid === 1'b1) begin
            if (strobe_cnt < 8) strobe_log[strobe_cnt] = cmd;
            strobe_cnt++;
            chk("strobe_while_busy", {31'd0, busy}, 0);
            chk("strobe_back_to_back", {31'd0, prev_cv}, 0);
        end else begin
            chk("cmd_idle_value", {28'd0, cmd}, 32'hF);
        end
        prev_cv = cmd_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_scr(input logic [3:0] a, input logic [3:0] d);
        scr_we = 1'b1; scr_addr = a; scr_data = d;
        cyc();
        scr_we = 1'b0;
    endtask

    // Controller model for the write phase: reads pixel i, writes result[i],
    // then pulses done.
    task automatic collect(input int n, input logic [7:0] xr);
        for (int i = 0; i < n; i++) begin
            IROM_rd = 1'b1; IROM_A = 6'(i);
            IRAM_valid = 1'b1; IRAM_A = 6'(i); IRAM_D = 8'(i) ^ xr;
            #1;
            chk("irom_q", {24'd0, IROM_Q}, i);
            cyc();
        end
        IRAM_valid = 1'b0; IROM_rd = 1'b0;
        done = 1'b1;
        cyc();
        done = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; img_we = 1'b0; img_addr = '0; img_data = '0;
        scr_we = 1'b0; scr_addr = '0; scr_data = '0; scr_len = '0; busy = 1'b1;
        done = 1'b0; IROM_rd = 1'b0; IROM_A = '0; IRAM_valid = 1'b0; IRAM_A = '0;
        IRAM_D = '0; res_rd_addr = '0;

        // Reset state
        #1;
        chk("rst_cmd", {28'd0, cmd}, 32'hF);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 0);
        chk("rst_irom_q", {24'd0, IROM_Q}, 0);
        chk("rst_wr_count", {25'd0, wr_count}, 0);
        chk("rst_run_done", {31'd0, run_done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // 1. Identity run
        for (int i = 0; i < 64; i++) begin
            img_we = 1'b1; img_addr = 6'(i); img_data = 8'(i);
            cyc();
        end
        img_we = 1'b0;
        wr_scr(4'd0, 4'd0);
        scr_len = 5'd1;
        start = 1'b1; busy = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("t1_wait_cmd_valid", {31'd0, cmd_valid}, 0);
        cyc();
        busy = 1'b0;
        #1;
        chk("t1_issue_valid", {31'd0, cmd_valid}, 1);
        chk("t1_issue_cmd", {28'd0, cmd}, 0);
        cyc();
        busy = 1'b1;
        collect(64, 8'h00);
        res_rd_addr = 6'd5;
        #1;
        chk("t1_run_done", {31'd0, run_done}, 1);
        chk("t1_error", {31'd0, error}, 0);
        chk("t1_wr_count", {25'd0, wr_count}, 64);
        chk("t1_res5", {24'd0, res_rd_data}, 5);

        // 2. Script order {SHIFT_UP, MAX, WRITE}
        wr_scr(4'd0, 4'd1);
        wr_scr(4'd1, 4'd5);
        wr_scr(4'd2, 4'd0);
        scr_len = 5'd3;
        strobe_cnt = 0;
        start = 1'b1; busy = 1'b1;
        cyc();
        start = 1'b0;
        cyc();                          // busy high 1 cycle
        busy = 1'b0; cyc();             // strobe SHIFT_UP
        busy = 1'b1;
        img_we = 1'b1; img_addr = 6'd5; img_data = 8'hEE;   // ignored in HOLD
        cyc();
        img_we = 1'b0;
        cyc(); cyc(); cyc();            // busy high 4 cycles total
        busy = 1'b0; cyc();             // strobe MAX
        cyc();                          // HOLD: no strobe despite busy low
        cyc();                          // strobe WRITE
        busy = 1'b1;
        collect(64, 8'hA5);             // irom_q at 5 must still read 5
        chk("t2_strobe_cnt", strobe_cnt, 3);
        chk("t2_strobe0", {28'd0, strobe_log[0]}, 1);
        chk("t2_strobe1", {28'd0, strobe_log[1]}, 5);
        chk("t2_strobe2", {28'd0, strobe_log[2]}, 0);
        chk("t2_run_done", {31'd0, run_done}, 1);
        chk("t2_error", {31'd0, error}, 0);
        chk("t2_wr_count", {25'd0, wr_count}, 64);
        res_rd_addr = 6'd10;
        #1;
        chk("t2_res10", {24'd0, res_rd_data}, 32'hAF);

        // Empty script -> immediate FIN with error
        scr_len = 5'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("len0_run_done", {31'd0, run_done}, 1);
        chk("len0_error", {31'd0, error}, 1);

        // 3. Short write count
        wr_scr(4'd0, 4'd0);
        scr_len = 5'd1;
        start = 1'b1; busy = 1'b1;
        cyc();
        start = 1'b0;
        busy = 1'b0; cyc();
        busy = 1'b1;
        collect(63, 8'h00);
        chk("t3_run_done", {31'd0, run_done}, 1);
        chk("t3_error", {31'd0, error}, 1);
        chk("t3_wr_count", {25'd0, wr_count}, 63);

        // 4. Watchdog with busy stuck high
        start = 1'b1; busy = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_cleared_error", {31'd0, error}, 0);
        repeat (1023) cyc();
        chk("t4_run_done_before", {31'd0, run_done}, 0);
        cyc();
        chk("t4_run_done_at", {31'd0, run_done}, 1);
        chk("t4_error", {31'd0, error}, 1);

        // 5a. Stray IRAM_valid in WAIT_RDY
        start = 1'b1; busy = 1'b1;
        cyc();
        start = 1'b0;
        IRAM_valid = 1'b1; IRAM_A = 6'd3; IRAM_D = 8'h77;
        cyc();
        IRAM_valid = 1'b0;
        chk("t5a_error", {31'd0, error}, 1);
        chk("t5a_wr_count", {25'd0, wr_count}, 0);
        busy = 1'b0; cyc();
        busy = 1'b1;
        collect(64, 8'h00);
        chk("t5a_error_sticky", {31'd0, error}, 1);
        chk("t5a_wr_count_end", {25'd0, wr_count}, 64);

        // 5b. Script {SHIFT_LEFT} without WRITE
        wr_scr(4'd0, 4'd3);
        scr_len = 5'd1;
        strobe_cnt = 0;
        start = 1'b1; busy = 1'b0;
        cyc();
        start = 1'b0;
        cyc();                          // strobe SHIFT_LEFT
        cyc();                          // HOLD
        chk("t5b_not_done_yet", {31'd0, run_done}, 0);
        cyc();                          // WAIT_RDY, script exhausted
        chk("t5b_run_done", {31'd0, run_done}, 1);
        chk("t5b_error", {31'd0, error}, 1);
        chk("t5b_wr_count", {25'd0, wr_count}, 0);
        chk("t5b_strobe_cnt", strobe_cnt, 1);
        chk("t5b_strobe0", {28'd0, strobe_log[0]}, 3);

        // 6. Reset mid-COLLECT
        wr_scr(4'd0, 4'd6);
        wr_scr(4'd1, 4'd0);
        scr_len = 5'd2;
        start = 1'b1; busy = 1'b0;
        cyc();
        start = 1'b0;
        cyc();                          // strobe MIN
        cyc();                          // HOLD
        cyc();                          // strobe WRITE
        busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            IRAM_valid = 1'b1; IRAM_A = 6'(i); IRAM_D = 8'(i);
            cyc();
        end
        IRAM_valid = 1'b0;
        chk("t6_pre_wr_count", {25'd0, wr_count}, 10);
        reset = 1'b0;
        #1;
        chk("t6_rst_wr_count", {25'd0, wr_count}, 0);
        chk("t6_rst_cmd", {28'd0, cmd}, 32'hF);
        chk("t6_rst_cmd_valid", {31'd0, cmd_valid}, 0);
        chk("t6_rst_run_done", {31'd0, run_done}, 0);
        chk("t6_rst_error", {31'd0, error}, 0);
        chk("t6_rst_irom_q", {24'd0, IROM_Q}, 0);
        cyc();
        reset = 1'b1;
        cyc();
        start = 1'b1; busy = 1'b1;
        cyc();
        start = 1'b0;
        busy = 1'b0;
        #1;
        chk("t6_reissue_valid", {31'd0, cmd_valid}, 1);
        chk("t6_reissue_cmd", {28'd0, cmd}, 6);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_host.md
# lcd_host

Host-side counterpart of the LCD image controller. Used in block-level and system-level benches, and as the on-chip host in FPGA bring-up. It serves the controller's image-ROM reads from a preloaded 64×8 image buffer, replays a preloaded command script over the `cmd`/`cmd_valid`/`busy` handshake, and captures the controller's image-RAM writes into a 64×8 result buffer. On `done` it reports completion and an error status.

## Interface

**Parameters**
- `CMD_DEPTH` — default 16. Number of script entries.
- `TIMEOUT` — default 1024. Watchdog limit in cycles.

**Ports** (`CW = log2(CMD_DEPTH)`)
- `clk` in 1. Single clock. All logic is rising-edge.
- `reset` in 1. Asynchronous, active-low.
- `start` in 1. Run request, one-cycle pulse. Honoured only in IDLE or FIN.
- `img_we` in 1, `img_addr` in 6, `img_data` in 8. Image preload port. Honoured only in IDLE or FIN.
- `scr_we` in 1, `scr_addr` in CW, `scr_data` in 4. Script preload port. Honoured only in IDLE or FIN.
- `scr_len` in CW+1. Number of valid script entries. Sampled on `start`.
- `cmd` out 4. Command to the controller.
- `cmd_valid` out 1. Command strobe.
- `busy` in 1. Controller busy.
- `done` in 1. Controller finished.
- `IROM_rd` in 1, `IROM_A` in 6. Image read request.
- `IROM_Q` out 8. Image read data.
- `IRAM_valid` in 1, `IRAM_A` in 6, `IRAM_D` in 8. Result write from the controller.
- `res_rd_addr` in 6. Result buffer read address.
- `res_rd_data` out 8. Result buffer read data.
- `wr_count` out 7. Number of captured writes.
- `run_done` out 1. Run finished.
- `error` out 1. Run failed.

## Operation

**State machine:** IDLE, WAIT_RDY, HOLD, COLLECT, FIN.

- **IDLE → WAIT_RDY** on `start`. Clears `ptr`, `wr_count`, `error`, `run_done`. If `scr_len==0`, go to FIN with `error=1` instead.
- **WAIT_RDY**
  - Issue is Mealy: when `busy==0`, drive `cmd_valid=1` and `cmd=script[ptr]` in that same cycle, then `ptr++`.
  - Issued `cmd==0` (WRITE) → COLLECT.
  - Any other issued command → HOLD.
  - If `ptr==scr_len` with no WRITE issued → FIN with `error=1`; no command is issued.
- **HOLD:** exactly one cycle; `busy` is ignored; then → WAIT_RDY. This guarantees at least one idle cycle between strobes.
- **COLLECT**
  - Each `IRAM_valid` writes `IRAM_D` to `result[IRAM_A]` and increments `wr_count`, saturating at 127.
  - Duplicate addresses are overwritten and still counted.
  - `done==1` → FIN. Set `error` if the final `wr_count != 64`, where the final count includes a write in the same cycle.
- **FIN:** `run_done=1` is held. `start` begins a new run, as from IDLE.

**Command port**
- When `cmd_valid==0`, `cmd` is 4'hF (CMD_IDLE).
- Never more than one strobe per command.

**Image port**
- `IROM_Q = IROM_rd ? image[IROM_A] : 8'd0`. Purely combinational.
- Valid in every state.

**Error conditions** (error is sticky until the next `start`)
- `IRAM_valid` outside COLLECT. The write is dropped and not counted.
- Watchdog: `wdog` clears on every state change and on every `IRAM_valid`; otherwise it increments in WAIT_RDY, HOLD and COLLECT. When `wdog==TIMEOUT-1`, set `error=1` and go to FIN.

**Other rules**
- Script codes 1–11 are passed through unchecked. Codes 12–15 in the script set `error` but are still issued.
- `res_rd_data = result[res_rd_addr]`, combinational.

## Timing

- **Reset values:** state IDLE, `cmd=4'hF`, `cmd_valid=0`, `IROM_Q=0`, `wr_count=0`, `run_done=0`, `error=0`. Buffer contents are not reset.
- **Reset mid-run:** immediate return to reset values, whatever the state.
- **Latency**
  - `busy` low → `cmd_valid`: 0 cycles.
  - `IROM_A` → `IROM_Q`: 0 cycles.
  - `IRAM_valid` → `res_rd_data` updated: 1 cycle.
  - `done` → `run_done`: 1 cycle.
- **Preload writes** take effect at the next edge. Preload strobes in other states are ignored.
- **`start` together with `img_we` in IDLE:** both act; the write lands before any read can occur.

## Structure

- **Shared package `lcd_pkg`:**
  - command codes WRITE=0, SHIFT_UP=1, SHIFT_DOWN=2, SHIFT_LEFT=3, SHIFT_RIGHT=4, MAX=5, MIN=6, AVE=7, LEFT_ROTATION=8, RIGHT_ROTATION=9, MIRROR_X=10, MIRROR_Y=11, CMD_IDLE=4'hF;
  - the host state enum;
  - `PIX_N=64`.
- **Sub-module `lcd_pixel_buf`:** 64×8, one synchronous write port, one combinational read port. Instantiated twice, for the image and the result.
- The script store is a local `CMD_DEPTH`×4 register array.

## Test plan

1. **Identity run.** Preload `img[i]=i`, script {WRITE}, `scr_len=1`, start; controller model keeps `busy=1` for 70 cycles while reading 0..63.
   - `IROM_Q` equals the address each cycle.
   - `cmd_valid=1`, `cmd=0` in the first cycle with `busy=0`.
   - 64 writes with `D=A` → `run_done=1`, `error=0`, `wr_count=64`, `res_rd_data@5=5`.
2. **Script order.** Script {SHIFT_UP, MAX, WRITE}; `busy` toggles high for 1, 4 and 70 cycles.
   - Exactly three strobes, with `cmd` 1, 5, 0, each in a cycle where `busy=0`.
   - At least one cycle between strobes; `cmd=4'hF` otherwise.
3. **Short write count.** `done` after 63 writes → `run_done=1`, `error=1`, `wr_count=63`.
4. **Watchdog.** `busy` stuck at 1 after start, `TIMEOUT=1024` → `error=1` and FIN exactly 1024 cycles after entering WAIT_RDY.
5. **Misuse.** Stray `IRAM_valid` in WAIT_RDY, and script {SHIFT_LEFT} without WRITE → `error=1` in both cases; `wr_count` unchanged.
6. **Reset mid-run.** Drive `reset=0` mid-COLLECT → outputs reach reset values before the next edge. After release, `start` reissues `script[0]`.
